// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams bitstream words MSB-first into a ccff configuration chain,
// gating the chain shift enable and tracking CRC-16-CCITT of bits entering and leaving it.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 32,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              cfg_clk_en,
  output logic              isol_n,
  output logic              busy,
  output logic              done,
  output logic [15:0]       head_crc,
  output logic [15:0]       tail_crc
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] LEN  = CW'(CHAIN_LEN);
  // min(WORD_W, CHAIN_LEN) always fits the counter width
  localparam logic [CW-1:0] WMAX = CW'(WORD_W < CHAIN_LEN ? WORD_W : CHAIN_LEN);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t            r_state, w_next;
  logic [CW-1:0]     r_rem, r_wcnt;
  logic [WORD_W-1:0] r_sr;
  logic              r_isol_n;
  logic [15:0]       r_head_crc, r_tail_crc;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  always_ff @(posedge prog_clk or posedge prog_reset)
    if (prog_reset) r_state <= IDLE;
    else            r_state <= w_next;

  always_comb begin
    w_next     = r_state;
    bs_ready   = 1'b0;
    cfg_clk_en = 1'b0;
    done       = 1'b0;
    busy       = 1'b0;
    ccff_head  = 1'b0;
    w_next = r_state == IDLE  ? (start ? FETCH : IDLE)
           : r_state == FETCH ? (bs_valid ? SHIFT : FETCH)
           : r_state == SHIFT ? (r_rem == ONE ? DONE : r_wcnt == ONE ? FETCH : SHIFT)
           : IDLE;
    bs_ready   = r_state == FETCH;
    cfg_clk_en = r_state == SHIFT;
    done       = r_state == DONE;
    busy       = r_state != IDLE;
    ccff_head  = (r_state == SHIFT) & r_sr[WORD_W-1];
  end

  always_ff @(posedge prog_clk or posedge prog_reset)
    if (prog_reset) begin
      r_rem      <= '0;
      r_wcnt     <= '0;
      r_sr       <= '0;
      r_isol_n   <= 1'b0;
      r_head_crc <= 16'hFFFF;
      r_tail_crc <= 16'hFFFF;
    end else if (r_state == IDLE) begin
      if (start) begin
        r_rem      <= LEN;
        r_isol_n   <= 1'b0;
        r_head_crc <= 16'hFFFF;
        r_tail_crc <= 16'hFFFF;
      end
    end else if (r_state == FETCH) begin
      if (bs_valid) begin
        r_sr   <= bs_data;
        r_wcnt <= r_rem < WMAX ? r_rem : WMAX;
      end
    end else if (r_state == SHIFT) begin
      r_sr       <= r_sr << 1;
      r_rem      <= r_rem - ONE;
      r_wcnt     <= r_wcnt - ONE;
      r_head_crc <= crc_step(r_head_crc, r_sr[WORD_W-1]);
      r_tail_crc <= crc_step(r_tail_crc, ccff_tail);
    end else begin
      r_isol_n <= 1'b1;
    end

  assign isol_n   = r_isol_n;
  assign head_crc = r_head_crc;
  assign tail_crc = r_tail_crc;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: randomized loads into a chain model, checked against bit-level
// expectations of head sequence, timing, CRCs, reset abort and a single-bit chain.
module tb_ccff_chain_loader;
  localparam int L  = 12;
  localparam int W  = 8;
  localparam int NW = (L + W - 1) / W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, bs_valid, bs_ready, ccff_head, ccff_tail, cfg_clk_en, isol_n, busy, done;
  logic [W-1:0] bs_data;
  logic [15:0] head_crc, tail_crc;
  logic [L-1:0] chain = '0;
  logic [L-1:0] exp_chain = '0;
  int errors = 0, checks = 0;

  logic s_start, s_valid, s_ready, s_head, s_tail, s_cfg, s_isol, s_busy, s_done;
  logic [7:0] s_data;
  logic [15:0] s_hcrc, s_tcrc;

  ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
    .prog_clk(clk), .prog_reset(rst), .start(start), .bs_data(bs_data), .bs_valid(bs_valid),
    .bs_ready(bs_ready), .ccff_head(ccff_head), .ccff_tail(ccff_tail), .cfg_clk_en(cfg_clk_en),
    .isol_n(isol_n), .busy(busy), .done(done), .head_crc(head_crc), .tail_crc(tail_crc));

  ccff_chain_loader #(.CHAIN_LEN(1), .WORD_W(8)) dut1 (
    .prog_clk(clk), .prog_reset(rst), .start(s_start), .bs_data(s_data), .bs_valid(s_valid),
    .bs_ready(s_ready), .ccff_head(s_head), .ccff_tail(s_tail), .cfg_clk_en(s_cfg),
    .isol_n(s_isol), .busy(s_busy), .done(s_done), .head_crc(s_hcrc), .tail_crc(s_tcrc));

  always @(posedge clk) if (cfg_clk_en) chain <= {chain[L-2:0], ccff_head};
  assign ccff_tail = chain[L-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_of(input logic [L-1:0] v);
    logic [15:0] c = 16'hFFFF;
    for (int i = L - 1; i >= 0; i--) c = (c << 1) ^ ((c[15] ^ v[i]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction

  task automatic reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bs_ready), 0);
    chk({tag, "_head"}, 32'(ccff_head), 0);
    chk({tag, "_en"}, 32'(cfg_clk_en), 0);
    chk({tag, "_isol"}, 32'(isol_n), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_hcrc"}, 32'(head_crc), 'hFFFF);
    chk({tag, "_tcrc"}, 32'(tail_crc), 'hFFFF);
  endtask

  task automatic run_load(input string tag, input logic [NW*W-1:0] words, input int stall,
                          input bit noise, input int abort_at);
    logic [L-1:0] bits = words[NW*W-1 -: L];
    logic [L-1:0] got = '0;
    logic [15:0] exp_tail = crc_of(exp_chain);
    int nf = 0, ns = 0, n = 0, wi = 0, st = stall, bad = 0;
    bit fin = 0;
    @(negedge clk) start = 1'b1; bs_valid = 1'b0;
    @(negedge clk);
    while (!fin && n < 200) begin
      n++;
      if (!busy || (bs_ready && cfg_clk_en) || (!cfg_clk_en && ccff_head) || isol_n) bad++;
      start = 1'b0; bs_valid = 1'b0; bs_data = W'($urandom);
      if (bs_ready) begin
        nf++;
        if (wi == 1 && st > 0) st--;
        else begin
          bs_valid = 1'b1;
          if (wi < NW) bs_data = words[NW*W-1-wi*W -: W];
          wi++;
        end
      end else if (cfg_clk_en) begin
        if (ns < L) got[L-1-ns] = ccff_head;
        ns++;
        if (noise) begin start = 1'($urandom); bs_valid = 1'($urandom); end
        if (ns == abort_at) begin
          rst = 1'b1; start = 1'b0; bs_valid = 1'b0;
          #1 reset_vals({tag, "_abort"});
          for (int k = 0; k < abort_at - 1; k++) exp_chain = {exp_chain[L-2:0], bits[L-1-k]};
          @(negedge clk) rst = 1'b0;
          return;
        end
      end
      if (done) fin = 1;
      else @(negedge clk);
    end
    chk({tag, "_timeout"}, 32'(fin), 1);
    chk({tag, "_seq"}, 32'(got), 32'(bits));
    chk({tag, "_cycles"}, n, NW + stall + L + 1);
    chk({tag, "_fetch"}, nf, NW + stall);
    chk({tag, "_shifts"}, ns, L);
    chk({tag, "_proto"}, bad, 0);
    chk({tag, "_hcrc"}, 32'(head_crc), 32'(crc_of(bits)));
    chk({tag, "_tcrc"}, 32'(tail_crc), 32'(exp_tail));
    exp_chain = bits;
    @(negedge clk);
    chk({tag, "_isol"}, 32'(isol_n), 1);
    chk({tag, "_idle"}, 32'({busy, done, bs_ready, cfg_clk_en}), 0);
    chk({tag, "_hold"}, 32'(head_crc), 32'(crc_of(bits)));
  endtask

  initial begin
    logic [NW*W-1:0] r;
    rst = 1'b1; start = 1'b0; bs_valid = 1'b0; bs_data = '0;
    s_start = 1'b0; s_valid = 1'b0; s_data = '0; s_tail = 1'b0;
    repeat (2) @(negedge clk);
    reset_vals("rst");
    rst = 1'b0;
    bs_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_valid_ignored", 32'({busy, bs_ready}), 0);
    bs_valid = 1'b0;
    run_load("a5c0", 16'hA5C0, 0, 0, 0);
    chk("a5c0_head_const", 32'(exp_chain), 'hA5C);
    run_load("stall", 16'hA5C0, 5, 0, 0);
    r = NW*W'($urandom);
    run_load("noise", r, 0, 1, 0);
    run_load("repeat", r, 0, 0, 0);
    chk("chain_crc", 32'(tail_crc), 32'(crc_of(r[NW*W-1 -: L])));
    run_load("abort", NW*W'($urandom), 0, 0, 5);
    run_load("after_abort", NW*W'($urandom), 0, 1, 0);
    for (int i = 0; i < 4; i++) run_load("rand", NW*W'($urandom), int'($urandom_range(0, 3)), 1, 0);
    @(negedge clk) s_start = 1'b1;
    @(negedge clk) s_start = 1'b0;
    chk("one_fetch", 32'({s_ready, s_cfg, s_busy}), 'b101);
    s_valid = 1'b1; s_data = 8'h80;
    @(negedge clk) s_valid = 1'b0;
    chk("one_shift", 32'({s_ready, s_cfg, s_head}), 'b011);
    @(negedge clk);
    chk("one_done", 32'({s_done, s_cfg}), 'b10);
    @(negedge clk);
    chk("one_after", 32'({s_done, s_isol, s_busy}), 'b010);
    chk("one_hcrc", 32'(s_hcrc), 'hFFFE);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
